// File: rtl/atmega_spi_s_if.sv
// Register-bus side of the SPI slave: CPU address/strobe/data, interrupt and pin-connect request.
interface atmega_spi_s_if #(
  parameter int BUS_ADDR_DATA_LEN = 8
);
  logic [BUS_ADDR_DATA_LEN-1:0] addr;
  logic                         wr;
  logic                         rd;
  logic [7:0]                   bus_in;
  logic [7:0]                   bus_out;
  logic                         irq;
  logic                         int_rst;
  logic                         io_connect;

  modport master (
    output addr, wr, rd, bus_in, int_rst,
    input  bus_out, irq, io_connect
  );

  modport slave (
    input  addr, wr, rd, bus_in, int_rst,
    output bus_out, irq, io_connect
  );
endinterface

// File: rtl/atmega_spi_s.sv
// ATmega-style SPI slave (SPCR/SPSR/SPDR); SPIF sets SYNC_STAGES+1 clk after the physical sample edge.
// Build option ATMEGA_SPI_S_RX_OVERRUN_EN: drop a byte that completes while SPIF is still set and flag OVR.
module atmega_spi_s #(
  parameter int                           BUS_ADDR_DATA_LEN = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR         = 'h20,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR         = 'h21,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR         = 'h22,
  parameter int                           SYNC_STAGES       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  atmega_spi_s_if.slave        bus,
  input  logic                 sck,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic sck_d, ss_d;
  logic sck_s, ss_s, mosi_s;
  logic sck_rise, sck_fall, ss_fall;

  logic [7:0] spcr, tx_hold, rx_data, rx_shift, tx_shift, rx_next;
  logic       spif, wcol, ovr, keep_old;
  logic [2:0] bit_cnt;
  logic       spe, dord, cpol, cpha;
  logic       lead_edge, trail_edge, run, sample, shift, byte_done, enter;
  logic       spcr_wr, spdr_wr, spsr_rd, status_clr, collide;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign ss_fall  = ~ss_s & ss_d;

  assign spe  = spcr[6];
  assign dord = spcr[5];
  assign cpol = spcr[3];
  assign cpha = spcr[2];

  assign lead_edge  = cpol ? sck_fall : sck_rise;
  assign trail_edge = cpol ? sck_rise : sck_fall;
  assign run        = (state == ACTIVE) && spe && !ss_s;
  assign sample     = run && (cpha ? trail_edge : lead_edge);
  // No shift before the first sample of a byte: the loaded first bit must stay on miso.
  assign shift      = run && (cpha ? lead_edge : trail_edge) && (bit_cnt != 3'd0);
  assign byte_done  = sample && (bit_cnt == 3'd7);
  assign rx_next    = dord ? {mosi_s, rx_shift[7:1]} : {rx_shift[6:0], mosi_s};

  assign spcr_wr    = bus.wr && (bus.addr == SPCR_ADDR);
  assign spdr_wr    = bus.wr && (bus.addr == SPDR_ADDR);
  assign spsr_rd    = bus.rd && (bus.addr == SPSR_ADDR);
  assign status_clr = spsr_rd || bus.int_rst;
  assign collide    = spdr_wr && (state == ACTIVE) && (bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    miso_oe   = 1'b0;
    miso      = 1'b1;
    case (state)
      IDLE: begin
        if (spe && ss_fall) begin
          state_nxt = ACTIVE;
          enter     = 1'b1;
        end
      end
      ACTIVE: begin
        miso_oe = 1'b1;
        miso    = dord ? tx_shift[0] : tx_shift[7];
        if (!spe || ss_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spcr     <= '0;
      tx_hold  <= '0;
      rx_data  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      bit_cnt  <= '0;
      spif     <= 1'b0;
      wcol     <= 1'b0;
    end else begin
      if (spcr_wr) spcr <= bus.bus_in;
      if (spdr_wr && !collide) tx_hold <= bus.bus_in;

      if (state == IDLE) begin
        bit_cnt <= '0;
        if (enter) tx_shift <= tx_hold;
      end else if (sample) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done) tx_shift <= tx_hold;
      end else if (shift) begin
        tx_shift <= dord ? {1'b0, tx_shift[7:1]} : {tx_shift[6:0], 1'b0};
      end

      if (byte_done && !keep_old) rx_data <= rx_next;

      if (byte_done)       spif <= 1'b1;
      else if (status_clr) spif <= 1'b0;

      if (collide)         wcol <= 1'b1;
      else if (status_clr) wcol <= 1'b0;
    end
  end

`ifdef ATMEGA_SPI_S_RX_OVERRUN_EN
  assign keep_old = spif;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  ovr <= 1'b0;
    else if (byte_done && spif) ovr <= 1'b1;
    else if (spsr_rd)          ovr <= 1'b0;
  end
`else
  assign keep_old = 1'b0;
  assign ovr      = 1'b0;
`endif

  always_comb begin
    bus.bus_out = '0;
    if (bus.rd) begin
      if (bus.addr == SPCR_ADDR)      bus.bus_out = spcr;
      else if (bus.addr == SPSR_ADDR) bus.bus_out = {spif, wcol, ovr, 5'b0};
      else if (bus.addr == SPDR_ADDR) bus.bus_out = rx_data;
    end
  end

  assign bus.irq        = spcr[7] & spif;
  assign bus.io_connect = spcr[6];

endmodule

// File: tb/tb_atmega_spi_s.sv
// Directed bench for atmega_spi_s: bit-banged SPI master plus register-bus accesses.
module tb_atmega_spi_s;
  localparam int          HALF = 60;
  localparam logic [7:0]  SPCR = 8'h20;
  localparam logic [7:0]  SPSR = 8'h21;
  localparam logic [7:0]  SPDR = 8'h22;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic sck  = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe;

  int vectors     = 0;
  int miscompares = 0;

  atmega_spi_s_if bif ();

  atmega_spi_s dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .sck     (sck),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bif.addr   = a;
    bif.bus_in = d;
    bif.wr     = 1'b1;
    @(negedge clk);
    bif.wr     = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bif.addr = a;
    bif.rd   = 1'b1;
    #1 d = bif.bus_out;
    @(negedge clk);
    bif.rd   = 1'b0;
  endtask

  // SPI master: drives mosi on its shift edge, captures miso on its sample edge.
  task automatic spi_xfer(input logic cpol, input logic cpha, input logic dord,
                          input logic [7:0] mtx, input int nbits, output logic [7:0] mrx);
    sck = cpol;
    mrx = 8'h00;
    #HALF;
    ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = dord ? i : 7 - i;
      if (!cpha) begin
        mosi = mtx[b];
        #HALF; sck = ~cpol; mrx[b] = miso;
        #HALF; sck = cpol;
      end else begin
        #HALF; sck = ~cpol; mosi = mtx[b];
        #HALF; sck = cpol; mrx[b] = miso;
      end
    end
    #HALF;
    ss_n = 1'b1;
    #HALF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rv, mrx;
    bif.addr    = '0;
    bif.wr      = 1'b0;
    bif.rd      = 1'b0;
    bif.bus_in  = '0;
    bif.int_rst = 1'b0;

    #23;
    check_vec("rst_irq", bif.irq, 0);
    check_vec("rst_io_connect", bif.io_connect, 0);
    check_vec("rst_miso", miso, 1);
    check_vec("rst_miso_oe", miso_oe, 0);
    check_vec("rst_bus_out", bif.bus_out, 0);
    @(negedge clk) rst = 1'b1;
    reg_rd(SPCR, rv); check_vec("rst_spcr", rv, 8'h00);
    reg_rd(SPSR, rv); check_vec("rst_spsr", rv, 8'h00);
    reg_rd(SPDR, rv); check_vec("rst_spdr", rv, 8'h00);

    // Mode 0, MSB first, SPIE on
    reg_wr(SPCR, 8'hC0);
    check_vec("io_connect_on", bif.io_connect, 1);
    reg_rd(SPCR, rv); check_vec("spcr_readback", rv, 8'hC0);
    reg_wr(SPDR, 8'hA5);
    spi_xfer(1'b0, 1'b0, 1'b0, 8'h3C, 8, mrx);
    check_vec("m0_master_rx", mrx, 8'hA5);
    check_vec("m0_irq", bif.irq, 1);
    check_vec("m0_idle_miso_oe", miso_oe, 0);
    check_vec("m0_idle_miso", miso, 1);
    reg_rd(SPSR, rv); check_vec("m0_spsr", rv, 8'h80);
    check_vec("m0_irq_cleared", bif.irq, 0);
    reg_rd(SPDR, rv); check_vec("m0_spdr", rv, 8'h3C);

    // Mode 3, LSB first, SPIE off
    reg_wr(SPCR, 8'h6C);
    reg_wr(SPDR, 8'h81);
    spi_xfer(1'b1, 1'b1, 1'b1, 8'h42, 8, mrx);
    check_vec("m3_master_rx", mrx, 8'h81);
    check_vec("m3_irq_masked", bif.irq, 0);
    reg_rd(SPSR, rv); check_vec("m3_spsr", rv, 8'h80);
    reg_rd(SPDR, rv); check_vec("m3_spdr", rv, 8'h42);

    // Write collision after three bits
    reg_wr(SPCR, 8'hC0);
    reg_wr(SPDR, 8'h96);
    fork
      spi_xfer(1'b0, 1'b0, 1'b0, 8'h5A, 8, mrx);
      begin
        repeat (3) @(posedge sck);
        #50;
        reg_wr(SPDR, 8'h55);
      end
    join
    check_vec("wcol_master_rx", mrx, 8'h96);
    reg_rd(SPSR, rv); check_vec("wcol_spsr", rv, 8'hC0);
    reg_rd(SPSR, rv); check_vec("wcol_spsr_cleared", rv, 8'h00);
    reg_rd(SPDR, rv); check_vec("wcol_spdr", rv, 8'h5A);
    spi_xfer(1'b0, 1'b0, 1'b0, 8'h00, 8, mrx);
    check_vec("wcol_hold_kept", mrx, 8'h96);
    reg_rd(SPSR, rv);

    // Partial byte aborted by ss_n, then a full byte
    spi_xfer(1'b0, 1'b0, 1'b0, 8'hFF, 5, mrx);
    check_vec("partial_irq", bif.irq, 0);
    check_vec("partial_miso_oe", miso_oe, 0);
    reg_rd(SPSR, rv); check_vec("partial_spsr", rv, 8'h00);
    spi_xfer(1'b0, 1'b0, 1'b0, 8'h99, 8, mrx);
    check_vec("full_irq", bif.irq, 1);
    reg_rd(SPDR, rv); check_vec("full_spdr", rv, 8'h99);
    @(negedge clk) bif.int_rst = 1'b1;
    @(negedge clk) bif.int_rst = 1'b0;
    check_vec("int_rst_clears", bif.irq, 0);

    // Two bytes with no status read in between
    spi_xfer(1'b0, 1'b0, 1'b0, 8'h11, 8, mrx);
    spi_xfer(1'b0, 1'b0, 1'b0, 8'h22, 8, mrx);
    reg_rd(SPDR, rv);
`ifdef ATMEGA_SPI_S_RX_OVERRUN_EN
    check_vec("ovr_spdr", rv, 8'h11);
    reg_rd(SPSR, rv); check_vec("ovr_spsr", rv, 8'hA0);
`else
    check_vec("ovr_spdr", rv, 8'h22);
    reg_rd(SPSR, rv); check_vec("ovr_spsr", rv, 8'h80);
`endif
    reg_rd(SPSR, rv); check_vec("ovr_spsr_cleared", rv, 8'h00);

    // Reset pulse during bit 4
    reg_wr(SPDR, 8'h3C);
    fork
      spi_xfer(1'b0, 1'b0, 1'b0, 8'h77, 8, mrx);
      begin
        repeat (4) @(posedge sck);
        #20;
        rst = 1'b0;
        #1;
        check_vec("midrst_miso_oe", miso_oe, 0);
        check_vec("midrst_miso", miso, 1);
        check_vec("midrst_irq", bif.irq, 0);
        check_vec("midrst_io_connect", bif.io_connect, 0);
        #30;
        rst = 1'b1;
      end
    join
    reg_rd(SPSR, rv); check_vec("midrst_spsr", rv, 8'h00);
    reg_rd(SPDR, rv); check_vec("midrst_spdr", rv, 8'h00);
    reg_wr(SPCR, 8'hC0);
    reg_wr(SPDR, 8'hA5);
    spi_xfer(1'b0, 1'b0, 1'b0, 8'hC3, 8, mrx);
    check_vec("postrst_master_rx", mrx, 8'hA5);
    check_vec("postrst_irq", bif.irq, 1);
    reg_rd(SPDR, rv); check_vec("postrst_spdr", rv, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
